s_axi4_fsb_adapter: RTL and testbench
=====================================

# s_axi4_fsb_adapter

AXI4 slave that converts host-to-card DMA writes on the PCIS port into an 80-bit FSB packet stream. It is the receive-direction counterpart of the FSB-to-PCIM write path, and it sits between the shell's 512-bit dma_pcis bus and a bsg_test_node client/master data input. Each 512-bit write beat carries up to four FSB packets. The adapter buffers one beat and serializes its packets onto the FSB valid/yumi interface. Reads are answered with SLVERR.

## Interface
- DATA_WIDTH, 512, AXI data width; must be a multiple of 128.
- FSB_WIDTH, 80, FSB packet width; must be ≤128.
- ID_WIDTH, 6, AXI ID width.
- ADDR_WIDTH, 64, AXI address width (address ignored).
- Derived: SLOTS = DATA_WIDTH/128 (4).

Ports:
- clk_i  in  1  sole clock.
- reset_i  in  1  synchronous, active-high reset.
- s_awid/awaddr/awlen[7:0]/awsize[2:0]/awvalid  in; s_awready  out.
- s_wdata[DATA_WIDTH]/wstrb[DATA_WIDTH/8]/wlast/wvalid  in; s_wready  out.
- s_bid[ID_WIDTH]/bresp[2]/bvalid  out; s_bready  in.
- s_arid/araddr/arlen[7:0]/arsize/arvalid  in; s_arready  out.
- s_rid/rdata/rresp/rlast/rvalid  out; s_rready  in.
- fsb_v_o  out  1  packet valid.
- fsb_data_o  out  FSB_WIDTH  packet.
- fsb_yumi_i  in  1  consumer takes the packet this cycle; only legal when fsb_v_o=1.

## Operation
- Slot k of a beat is wdata[128k+FSB_WIDTH-1 : 128k].
- Slot k is valid iff wstrb[16k+9 : 16k] is all ones (the 10 bytes covering the 80-bit packet). Partial strobes drop the slot silently.
- Write FSM:
  - W_IDLE: awready=1. On the AW handshake, capture awid and go to W_DATA.
  - W_DATA: wready = (slot mask == 0). On the W handshake, load the beat register and set mask = per-slot valid bits. If wlast, go to W_RESP.
  - W_RESP: bvalid=1, bid=captured id, bresp=2'b00. On bready, go to W_IDLE.
- B is issued after the last beat is captured; it does not wait for the FSB drain.
- A beat with all slots invalid is consumed in one cycle and leaves the mask at 0.
- awlen, awsize and awaddr are ignored. Beat count is governed solely by wlast.
- Serializer:
  - fsb_v_o = |mask.
  - fsb_data_o = the lowest-index set slot.
  - On fsb_yumi_i, clear that slot's mask bit.
  - Packets leave in slot order 0→3.
- Read FSM:
  - R_IDLE: arready=1. On the AR handshake, capture arid and arlen, clear the 8-bit beat counter, and go to R_DATA.
  - R_DATA: rvalid=1, rdata=0, rresp=2'b10, rid=captured id, rlast = (count == arlen). Each rready increments count. rready with rlast returns to R_IDLE.
- The read and write channels are fully independent and may be active simultaneously.

## Timing
- Reset values: every valid/ready output is 0. bid, bresp, rid, rdata, rresp and fsb_data_o are 0. The mask is cleared and both FSMs are in IDLE.
- awready and arready rise in the first cycle after reset_i deasserts.
- AW handshake at cycle t → earliest W handshake at t+1. W is never accepted in the same cycle as its AW.
- W handshake at cycle t → fsb_v_o=1 at t+1 if any slot is valid.
- With yumi held high, a full beat drains in SLOTS cycles. wready reasserts the cycle after the final yumi, giving one-beat-per-5-cycles throughput.
- Last W handshake at t → bvalid at t+1. The next awready is at the cycle after the bready handshake.
- AR handshake at t → first rvalid at t+1. Beats stream back-to-back while rready=1.
- fsb_data_o and fsb_v_o hold stable while fsb_yumi_i=0.
- rvalid and bvalid hold with stable payload until their ready is seen.
- Reset mid-transaction: in-flight beats, pending B and pending R are discarded, and no response is issued.

## Test plan
- Single-beat write, awid=5, wlast=1, full wstrb, slots = 80'h1…, 80'h2…, 80'h3…, 80'h4…, yumi tied 1 → packets 1,2,3,4 on 4 consecutive cycles starting at t+1; bvalid with bid=5, bresp=0 at t+1.
- wstrb valid for slots 0 and 2 only, slot 1 missing byte 9 → exactly two packets (slot 0, then slot 2); wready returns 0→1 after the second yumi.
- 3-beat burst with fsb_yumi_i toggling 1,0,1,0… → 12 packets in order, data stable during yumi=0; bvalid follows the third beat's capture.
- Read with arid=9, arlen=3, rready stalled every other cycle → 4 beats with rdata=0, rresp=2'b10, rid=9, rlast only on beat 4.
- Concurrent 2-beat write and arlen=1 read issued the same cycle → both complete correctly with no interaction between channels.
- reset_i pulsed while mask=4'b1100 and bvalid pending → after reset fsb_v_o=0, bvalid=0, awready=1; a following write behaves normally.

Source files
------------

// File: rtl/s_axi4_fsb_adapter.sv
// s_axi4_fsb_adapter: AXI4 write slave that unpacks each 512-bit beat into up to
// four 80-bit FSB packets and serializes them onto a valid/yumi stream.
// Reads are never served; every read beat returns SLVERR with zero data.
module s_axi4_fsb_adapter #(
    parameter int DATA_WIDTH = 512,
    parameter int FSB_WIDTH  = 80,
    parameter int ID_WIDTH   = 6,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                      clk_i,
    input  logic                      reset_i,

    input  logic [ID_WIDTH-1:0]       s_awid,
    input  logic [ADDR_WIDTH-1:0]     s_awaddr,
    input  logic [7:0]                s_awlen,
    input  logic [2:0]                s_awsize,
    input  logic                      s_awvalid,
    output logic                      s_awready,

    input  logic [DATA_WIDTH-1:0]     s_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
    input  logic                      s_wlast,
    input  logic                      s_wvalid,
    output logic                      s_wready,

    output logic [ID_WIDTH-1:0]       s_bid,
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,

    input  logic [ID_WIDTH-1:0]       s_arid,
    input  logic [ADDR_WIDTH-1:0]     s_araddr,
    input  logic [7:0]                s_arlen,
    input  logic [2:0]                s_arsize,
    input  logic                      s_arvalid,
    output logic                      s_arready,

    output logic [ID_WIDTH-1:0]       s_rid,
    output logic [DATA_WIDTH-1:0]     s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rlast,
    output logic                      s_rvalid,
    input  logic                      s_rready,

    output logic                      fsb_v_o,
    output logic [FSB_WIDTH-1:0]      fsb_data_o,
    input  logic                      fsb_yumi_i
);

    localparam int SLOTS = DATA_WIDTH / 128;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    typedef logic [SLOTS-1:0][FSB_WIDTH-1:0] beat_t;

    // A slot carries a packet only if all ten bytes of the packet are strobed.
    function automatic logic [SLOTS-1:0] slot_mask_f(input logic [DATA_WIDTH/8-1:0] strb);
        logic [SLOTS-1:0] m;
        m = {SLOTS{1'b0}};
        for (int k = 0; k < SLOTS; k++) begin
            m[k] = &strb[16*k +: 10];
        end
        return m;
    endfunction

    // Each slot's packet sits in the low FSB_WIDTH bits of its 128-bit lane.
    function automatic beat_t unpack_f(input logic [DATA_WIDTH-1:0] data);
        beat_t b;
        for (int k = 0; k < SLOTS; k++) begin
            b[k] = data[128*k +: FSB_WIDTH];
        end
        return b;
    endfunction

    // Lowest-index pending slot wins, so packets leave in slot order.
    function automatic logic [FSB_WIDTH-1:0] select_f(input logic [SLOTS-1:0] m,
                                                      input beat_t b);
        logic [FSB_WIDTH-1:0] sel;
        sel = {FSB_WIDTH{1'b0}};
        for (int k = SLOTS - 1; k >= 0; k--) begin
            sel = m[k] ? b[k] : sel;
        end
        return sel;
    endfunction

    // Write side state
    w_state_e               w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]    bid_q, bid_d;
    logic                   awready_q, awready_d;
    logic                   wready_q, wready_d;
    logic                   bvalid_q, bvalid_d;
    logic [SLOTS-1:0]       mask_q, mask_d;
    beat_t                  beat_q, beat_d;
    logic                   fsb_v_q, fsb_v_d;
    logic [FSB_WIDTH-1:0]   fsb_data_q, fsb_data_d;

    // Read side state
    r_state_e               r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]    rid_q, rid_d;
    logic [7:0]             arlen_q, arlen_d;
    logic [7:0]             rcnt_q, rcnt_d;
    logic                   arready_q, arready_d;
    logic                   rvalid_q, rvalid_d;
    logic                   rlast_q, rlast_d;
    logic [1:0]             rresp_q, rresp_d;

    logic aw_hs_s, w_hs_s, b_hs_s, yumi_s, ar_hs_s, r_hs_s;

    // Address, size, length and the strobe/data bits outside packet lanes carry no meaning here.
    logic unused_s;
    assign unused_s = ^{s_awaddr, s_awlen, s_awsize, s_araddr, s_arsize, s_wdata, s_wstrb};

    assign aw_hs_s = s_awvalid & awready_q;
    assign w_hs_s  = s_wvalid & wready_q;
    assign b_hs_s  = bvalid_q & s_bready;
    assign yumi_s  = fsb_yumi_i & fsb_v_q;
    assign ar_hs_s = s_arvalid & arready_q;
    assign r_hs_s  = rvalid_q & s_rready;

    // Write FSM, beat capture and serializer next-state; outputs are precomputed for the next cycle.
    always_comb begin
        w_state_d = w_state_q;
        bid_d     = bid_q;
        beat_d    = beat_q;
        if (yumi_s) begin
            mask_d = mask_q & (mask_q - SLOTS'(1'b1));
        end else begin
            mask_d = mask_q;
        end

        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_s) begin
                    bid_d     = s_awid;
                    w_state_d = W_DATA;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_DATA: begin
                if (w_hs_s) begin
                    beat_d    = unpack_f(s_wdata);
                    mask_d    = slot_mask_f(s_wstrb);
                    w_state_d = s_wlast ? W_RESP : W_DATA;
                end else begin
                    w_state_d = W_DATA;
                end
            end
            W_RESP: begin
                if (b_hs_s) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase

        awready_d  = (w_state_d == W_IDLE);
        wready_d   = (w_state_d == W_DATA) && (mask_d == {SLOTS{1'b0}});
        bvalid_d   = (w_state_d == W_RESP);
        fsb_v_d    = |mask_d;
        fsb_data_d = select_f(mask_d, beat_d);
    end

    // Read FSM next-state: count beats and flag the last one against the captured arlen.
    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        arlen_d   = arlen_q;
        rcnt_d    = rcnt_q;

        case (r_state_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    rid_d     = s_arid;
                    arlen_d   = s_arlen;
                    rcnt_d    = 8'd0;
                    r_state_d = R_DATA;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (r_hs_s && rlast_q) begin
                    r_state_d = R_IDLE;
                end else if (r_hs_s) begin
                    rcnt_d = rcnt_q + 8'd1;
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase

        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
        rlast_d   = rvalid_d && (rcnt_d == arlen_d);
        rresp_d   = rvalid_d ? 2'b10 : 2'b00;
    end

    // Write-side registers; reset drops any in-flight beat and pending response.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            w_state_q  <= W_IDLE;
            bid_q      <= {ID_WIDTH{1'b0}};
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            mask_q     <= {SLOTS{1'b0}};
            beat_q     <= {(SLOTS*FSB_WIDTH){1'b0}};
            fsb_v_q    <= 1'b0;
            fsb_data_q <= {FSB_WIDTH{1'b0}};
        end else begin
            w_state_q  <= w_state_d;
            bid_q      <= bid_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            mask_q     <= mask_d;
            beat_q     <= beat_d;
            fsb_v_q    <= fsb_v_d;
            fsb_data_q <= fsb_data_d;
        end
    end

    // Read-side registers; reset abandons any read burst without completing it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state_q <= R_IDLE;
            rid_q     <= {ID_WIDTH{1'b0}};
            arlen_q   <= 8'd0;
            rcnt_q    <= 8'd0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'b00;
        end else begin
            r_state_q <= r_state_d;
            rid_q     <= rid_d;
            arlen_q   <= arlen_d;
            rcnt_q    <= rcnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
        end
    end

    assign s_awready  = awready_q;
    assign s_wready   = wready_q;
    assign s_bid      = bid_q;
    assign s_bresp    = 2'b00;
    assign s_bvalid   = bvalid_q;
    assign s_arready  = arready_q;
    assign s_rid      = rid_q;
    assign s_rdata    = {DATA_WIDTH{1'b0}};
    assign s_rresp    = rresp_q;
    assign s_rlast    = rlast_q;
    assign s_rvalid   = rvalid_q;
    assign fsb_v_o    = fsb_v_q;
    assign fsb_data_o = fsb_data_q;

endmodule

// File: tb/tb_s_axi4_fsb_adapter.sv
// Directed bench for s_axi4_fsb_adapter: write serialization, strobe filtering,
// bursts with back-pressure, error reads, concurrent channels and mid-flight reset.
module tb_s_axi4_fsb_adapter;

    localparam int DW = 512;
    localparam int FW = 80;
    localparam int IW = 6;
    localparam int AW = 64;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic [IW-1:0]   s_awid;
    logic [AW-1:0]   s_awaddr;
    logic [7:0]      s_awlen;
    logic [2:0]      s_awsize;
    logic            s_awvalid;
    logic            s_awready;
    logic [DW-1:0]   s_wdata;
    logic [DW/8-1:0] s_wstrb;
    logic            s_wlast;
    logic            s_wvalid;
    logic            s_wready;
    logic [IW-1:0]   s_bid;
    logic [1:0]      s_bresp;
    logic            s_bvalid;
    logic            s_bready;
    logic [IW-1:0]   s_arid;
    logic [AW-1:0]   s_araddr;
    logic [7:0]      s_arlen;
    logic [2:0]      s_arsize;
    logic            s_arvalid;
    logic            s_arready;
    logic [IW-1:0]   s_rid;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rlast;
    logic            s_rvalid;
    logic            s_rready;
    logic            fsb_v_o;
    logic [FW-1:0]   fsb_data_o;
    logic            fsb_yumi_i;

    int total = 0;
    int bad   = 0;

    s_axi4_fsb_adapter dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .fsb_v_o(fsb_v_o), .fsb_data_o(fsb_data_o), .fsb_yumi_i(fsb_yumi_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [FW-1:0] pkt(input int b, input int k);
        return {8'(b), 8'(k), 64'h0123_4567_89AB_CDEF ^ {8{8'(b * 4 + k)}}};
    endfunction

    // Upper 48 bits of each 128-bit lane get junk that must never appear on the FSB.
    function automatic logic [DW-1:0] mkbeat(input int b);
        logic [DW-1:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            w[128*k +: FW]      = pkt(b, k);
            w[128*k + FW +: 48] = {32'hDEAD_BEEF, 16'(k)};
        end
        return w;
    endfunction

    task automatic test_reset();
        reset_i = 1'b1;
        tick();
        tick();
        total++; if (s_awready !== 1'b0) begin bad++; $display("FAIL rst_awready got=%0h exp=0", s_awready); end
        total++; if (s_arready !== 1'b0) begin bad++; $display("FAIL rst_arready got=%0h exp=0", s_arready); end
        total++; if (s_wready !== 1'b0) begin bad++; $display("FAIL rst_wready got=%0h exp=0", s_wready); end
        total++; if (s_bvalid !== 1'b0 || s_bid !== 6'd0 || s_bresp !== 2'b00) begin bad++; $display("FAIL rst_b got=%0h/%0h/%0h exp=0/0/0", s_bvalid, s_bid, s_bresp); end
        total++; if (s_rvalid !== 1'b0 || s_rid !== 6'd0 || s_rresp !== 2'b00 || s_rdata !== '0) begin bad++; $display("FAIL rst_r got=%0h/%0h/%0h exp=0/0/0", s_rvalid, s_rid, s_rresp); end
        total++; if (fsb_v_o !== 1'b0 || fsb_data_o !== 80'd0) begin bad++; $display("FAIL rst_fsb got=%0h/%0h exp=0/0", fsb_v_o, fsb_data_o); end
        reset_i = 1'b0;
        tick();
        total++; if (s_awready !== 1'b1) begin bad++; $display("FAIL rst_awready_rise got=%0h exp=1", s_awready); end
        total++; if (s_arready !== 1'b1) begin bad++; $display("FAIL rst_arready_rise got=%0h exp=1", s_arready); end
        total++; if (s_wready !== 1'b0) begin bad++; $display("FAIL rst_wready_idle got=%0h exp=0", s_wready); end
    endtask

    task automatic test_single(input logic [IW-1:0] id, input int b);
        s_awid = id; s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        total++; if (s_awready !== 1'b0) begin bad++; $display("FAIL single_awready_low got=%0h exp=0", s_awready); end
        total++; if (s_wready !== 1'b1) begin bad++; $display("FAIL single_wready got=%0h exp=1", s_wready); end
        s_wdata = mkbeat(b); s_wstrb = '1; s_wlast = 1'b1; s_wvalid = 1'b1; fsb_yumi_i = 1'b1;
        tick();
        s_wvalid = 1'b0;
        total++; if (s_bvalid !== 1'b1 || s_bid !== id || s_bresp !== 2'b00) begin bad++; $display("FAIL single_b got=%0h/%0h/%0h exp=1/%0h/0", s_bvalid, s_bid, s_bresp, id); end
        total++; if (s_wready !== 1'b0) begin bad++; $display("FAIL single_wready_low got=%0h exp=0", s_wready); end
        for (int k = 0; k < 4; k++) begin
            total++; if (fsb_v_o !== 1'b1 || fsb_data_o !== pkt(b, k)) begin bad++; $display("FAIL single_pkt%0d got=%0h/%0h exp=1/%0h", k, fsb_v_o, fsb_data_o, pkt(b, k)); end
            tick();
        end
        total++; if (fsb_v_o !== 1'b0) begin bad++; $display("FAIL single_drained got=%0h exp=0", fsb_v_o); end
        total++; if (s_bvalid !== 1'b1) begin bad++; $display("FAIL single_b_hold got=%0h exp=1", s_bvalid); end
        fsb_yumi_i = 1'b0; s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        total++; if (s_bvalid !== 1'b0 || s_awready !== 1'b1) begin bad++; $display("FAIL single_b_done got=%0h/%0h exp=0/1", s_bvalid, s_awready); end
    endtask

    task automatic test_partial();
        logic [DW/8-1:0] st;
        st = '0;
        st[9:0]   = '1;
        st[24:16] = '1;
        st[41:32] = '1;
        st[63:58] = '1;
        s_awid = 6'd3; s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        s_wdata = mkbeat(1); s_wstrb = st; s_wlast = 1'b0; s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        total++; if (fsb_v_o !== 1'b1 || fsb_data_o !== pkt(1, 0)) begin bad++; $display("FAIL partial_slot0 got=%0h/%0h exp=1/%0h", fsb_v_o, fsb_data_o, pkt(1, 0)); end
        total++; if (s_wready !== 1'b0) begin bad++; $display("FAIL partial_wready_busy got=%0h exp=0", s_wready); end
        fsb_yumi_i = 1'b1;
        tick();
        total++; if (fsb_v_o !== 1'b1 || fsb_data_o !== pkt(1, 2)) begin bad++; $display("FAIL partial_slot2 got=%0h/%0h exp=1/%0h", fsb_v_o, fsb_data_o, pkt(1, 2)); end
        total++; if (s_wready !== 1'b0) begin bad++; $display("FAIL partial_wready_busy2 got=%0h exp=0", s_wready); end
        tick();
        fsb_yumi_i = 1'b0;
        total++; if (fsb_v_o !== 1'b0) begin bad++; $display("FAIL partial_two_only got=%0h exp=0", fsb_v_o); end
        total++; if (s_wready !== 1'b1) begin bad++; $display("FAIL partial_wready_back got=%0h exp=1", s_wready); end
        s_wstrb = '0; s_wlast = 1'b1; s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        total++; if (fsb_v_o !== 1'b0 || s_bvalid !== 1'b1 || s_bid !== 6'd3) begin bad++; $display("FAIL partial_empty_beat got=%0h/%0h/%0h exp=0/1/3", fsb_v_o, s_bvalid, s_bid); end
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        total++; if (s_bvalid !== 1'b0 || s_awready !== 1'b1) begin bad++; $display("FAIL partial_b_done got=%0h/%0h exp=0/1", s_bvalid, s_awready); end
    endtask

    task automatic test_burst();
        int bb, idx, cyc;
        logic tog, prevv, prevy, hsw, lastw;
        logic [FW-1:0] prevd;
        bb = 0; idx = 0; cyc = 0; tog = 1'b1; prevv = 1'b0; prevy = 1'b0; prevd = '0;
        s_awid = 6'd2; s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        s_wdata = mkbeat(2); s_wstrb = '1; s_wlast = 1'b0; s_wvalid = 1'b1;
        while (cyc < 200 && !(idx == 12 && bb == 3)) begin
            if (prevv && !prevy) begin
                total++; if (fsb_v_o !== 1'b1 || fsb_data_o !== prevd) begin bad++; $display("FAIL burst_stable got=%0h/%0h exp=1/%0h", fsb_v_o, fsb_data_o, prevd); end
            end
            fsb_yumi_i = tog & fsb_v_o;
            tog = ~tog;
            if (fsb_v_o && fsb_yumi_i) begin
                total++; if (fsb_data_o !== pkt(2 + idx / 4, idx % 4)) begin bad++; $display("FAIL burst_pkt%0d got=%0h exp=%0h", idx, fsb_data_o, pkt(2 + idx / 4, idx % 4)); end
                idx++;
            end
            hsw   = s_wvalid && s_wready;
            lastw = hsw && s_wlast;
            prevv = fsb_v_o; prevy = fsb_yumi_i; prevd = fsb_data_o;
            if (lastw) begin
                total++; if (s_bvalid !== 1'b0) begin bad++; $display("FAIL burst_b_early got=%0h exp=0", s_bvalid); end
            end
            tick();
            cyc++;
            if (lastw) begin
                total++; if (s_bvalid !== 1'b1 || s_bid !== 6'd2) begin bad++; $display("FAIL burst_b got=%0h/%0h exp=1/2", s_bvalid, s_bid); end
            end
            if (hsw) begin
                bb++;
                if (bb == 3) begin
                    s_wvalid = 1'b0;
                end else begin
                    s_wdata = mkbeat(2 + bb);
                    s_wlast = (bb == 2);
                end
            end
        end
        fsb_yumi_i = 1'b0; s_wvalid = 1'b0;
        total++; if (idx !== 12 || bb !== 3) begin bad++; $display("FAIL burst_count got=%0d/%0d exp=12/3", idx, bb); end
        total++; if (fsb_v_o !== 1'b0) begin bad++; $display("FAIL burst_drained got=%0h exp=0", fsb_v_o); end
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        total++; if (s_bvalid !== 1'b0 || s_awready !== 1'b1) begin bad++; $display("FAIL burst_b_done got=%0h/%0h exp=0/1", s_bvalid, s_awready); end
    endtask

    task automatic test_read();
        int beat, cyc;
        beat = 0; cyc = 0;
        s_arid = 6'd9; s_arlen = 8'd3; s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        total++; if (s_arready !== 1'b0) begin bad++; $display("FAIL read_arready_low got=%0h exp=0", s_arready); end
        while (cyc < 40 && beat < 4) begin
            total++; if (s_rvalid !== 1'b1 || s_rid !== 6'd9 || s_rresp !== 2'b10 || s_rdata !== '0) begin bad++; $display("FAIL read_beat%0d got=%0h/%0h/%0h exp=1/9/2", beat, s_rvalid, s_rid, s_rresp); end
            total++; if (s_rlast !== (beat == 3)) begin bad++; $display("FAIL read_rlast%0d got=%0h exp=%0h", beat, s_rlast, (beat == 3)); end
            s_rready = (cyc % 2 == 1);
            if (s_rready) beat++;
            tick();
            cyc++;
        end
        s_rready = 1'b0;
        total++; if (beat !== 4) begin bad++; $display("FAIL read_count got=%0d exp=4", beat); end
        total++; if (s_rvalid !== 1'b0 || s_arready !== 1'b1) begin bad++; $display("FAIL read_done got=%0h/%0h exp=0/1", s_rvalid, s_arready); end
    endtask

    task automatic test_concurrent();
        int bb, rb, pk, cyc;
        logic bdone, hsw;
        bb = 0; rb = 0; pk = 0; cyc = 0; bdone = 1'b0;
        s_awid = 6'd7; s_arid = 6'd11; s_arlen = 8'd1;
        s_awvalid = 1'b1; s_arvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_arvalid = 1'b0;
        total++; if (s_awready !== 1'b0 || s_arready !== 1'b0) begin bad++; $display("FAIL conc_accept got=%0h/%0h exp=0/0", s_awready, s_arready); end
        s_wdata = mkbeat(5); s_wstrb = '1; s_wlast = 1'b0; s_wvalid = 1'b1;
        s_rready = 1'b1; s_bready = 1'b1;
        while (cyc < 60 && !(pk == 8 && rb == 2 && bdone && bb == 2)) begin
            fsb_yumi_i = fsb_v_o;
            if (fsb_v_o) begin
                total++; if (fsb_data_o !== pkt(5 + pk / 4, pk % 4)) begin bad++; $display("FAIL conc_pkt%0d got=%0h exp=%0h", pk, fsb_data_o, pkt(5 + pk / 4, pk % 4)); end
                pk++;
            end
            if (s_rvalid) begin
                total++; if (s_rid !== 6'd11 || s_rlast !== (rb == 1) || s_rresp !== 2'b10) begin bad++; $display("FAIL conc_r%0d got=%0h/%0h/%0h exp=b/%0h/2", rb, s_rid, s_rlast, s_rresp, (rb == 1)); end
                rb++;
            end
            if (s_bvalid) begin
                total++; if (s_bid !== 6'd7 || s_bresp !== 2'b00) begin bad++; $display("FAIL conc_b got=%0h/%0h exp=7/0", s_bid, s_bresp); end
                bdone = 1'b1;
            end
            hsw = s_wvalid && s_wready;
            tick();
            cyc++;
            if (hsw) begin
                bb++;
                if (bb == 2) begin
                    s_wvalid = 1'b0;
                end else begin
                    s_wdata = mkbeat(6);
                    s_wlast = 1'b1;
                end
            end
        end
        fsb_yumi_i = 1'b0; s_rready = 1'b0; s_bready = 1'b0; s_wvalid = 1'b0;
        total++; if (pk !== 8 || rb !== 2 || bdone !== 1'b1) begin bad++; $display("FAIL conc_counts got=%0d/%0d/%0h exp=8/2/1", pk, rb, bdone); end
        total++; if (s_rvalid !== 1'b0 || s_bvalid !== 1'b0 || fsb_v_o !== 1'b0) begin bad++; $display("FAIL conc_quiet got=%0h/%0h/%0h exp=0/0/0", s_rvalid, s_bvalid, fsb_v_o); end
        total++; if (s_awready !== 1'b1 || s_arready !== 1'b1) begin bad++; $display("FAIL conc_idle got=%0h/%0h exp=1/1", s_awready, s_arready); end
    endtask

    task automatic test_reset_mid();
        s_awid = 6'd1; s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        s_wdata = mkbeat(9); s_wstrb = '1; s_wlast = 1'b1; s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        fsb_yumi_i = 1'b1;
        tick();
        tick();
        fsb_yumi_i = 1'b0;
        total++; if (fsb_v_o !== 1'b1 || fsb_data_o !== pkt(9, 2) || s_bvalid !== 1'b1) begin bad++; $display("FAIL mid_setup got=%0h/%0h/%0h exp=1/%0h/1", fsb_v_o, fsb_data_o, s_bvalid, pkt(9, 2)); end
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        total++; if (fsb_v_o !== 1'b0 || s_bvalid !== 1'b0) begin bad++; $display("FAIL mid_flush got=%0h/%0h exp=0/0", fsb_v_o, s_bvalid); end
        tick();
        total++; if (s_awready !== 1'b1 || fsb_v_o !== 1'b0 || s_bvalid !== 1'b0) begin bad++; $display("FAIL mid_after got=%0h/%0h/%0h exp=1/0/0", s_awready, fsb_v_o, s_bvalid); end
    endtask

    initial begin
        reset_i = 1'b1;
        s_awid = '0; s_awaddr = 64'h0000_0010_DEAD_0000; s_awlen = 8'd7; s_awsize = 3'd6; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
        s_arid = '0; s_araddr = 64'h0000_0020_BEEF_0000; s_arlen = 8'd0; s_arsize = 3'd6; s_arvalid = 1'b0;
        s_rready = 1'b0; fsb_yumi_i = 1'b0;
        test_reset();
        test_single(6'd5, 0);
        test_partial();
        test_burst();
        test_read();
        test_concurrent();
        test_reset_mid();
        test_single(6'd6, 8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
